dpram_fifo_ctrl: RTL

DPRAM_FIFO_CTRL -- requirements
Module: dpram_fifo_ctrl

---
 rtl/dpram_fifo_ctrl_pkg.sv | 15 +
 rtl/dpram_rd_skid.sv | 44 ++++
 rtl/dpram_fifo_ctrl.sv | 80 ++++++++
 3 files changed

// File: rtl/dpram_fifo_ctrl_pkg.sv
// dpram_fifo_ctrl_pkg: width and depth derivations shared by the FIFO controller and its skid buffer
package dpram_fifo_ctrl_pkg;
  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction
  function automatic int cnt_width(input int aw);
    return aw + 2;
  endfunction
  function automatic int buf_depth(input int od);
    return od + 1;
  endfunction
  function automatic int cnt_bits(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/dpram_rd_skid.sv
// dpram_rd_skid: small register FIFO catching RAM read data so the consumer can stall freely
module dpram_rd_skid
  import dpram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_push,
  input  logic [DATA_WIDTH-1:0]          i_data,
  input  logic                           i_pop,
  output logic [DATA_WIDTH-1:0]          o_data,
  output logic                           o_valid,
  output logic [cnt_bits(DEPTH)-1:0]     o_count
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_bits(DEPTH);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [IW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_pop;
  always_comb begin
    o_valid = cnt_q != '0;
    o_data  = mem_q[rd_q];
    o_count = cnt_q;
    do_pop  = i_pop && o_valid;
    wr_d    = i_push ? ((wr_q == IW'(DEPTH - 1)) ? '0 : wr_q + IW'(1)) : wr_q;
    rd_d    = do_pop ? ((rd_q == IW'(DEPTH - 1)) ? '0 : rd_q + IW'(1)) : rd_q;
    cnt_d   = cnt_q + CW'(i_push) - CW'(do_pop);
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge i_clk)
    if (i_push) mem_q[wr_q] <= i_data;
endmodule

// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl: FIFO control around an external dual-port RAM with credit-limited pipelined reads
module dpram_fifo_ctrl
  import dpram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int OUT_DELAY = 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_wr_valid,
  output logic                            o_wr_ready,
  input  logic [DATA_WIDTH-1:0]           i_wr_data,
  output logic                            o_rd_valid,
  input  logic                            i_rd_ready,
  output logic [DATA_WIDTH-1:0]           o_rd_data,
  output logic [cnt_width(ADDR_WIDTH)-1:0] o_count,
  output logic                            o_ram_we_a,
  output logic [ADDR_WIDTH-1:0]           o_ram_addr_a,
  output logic [DATA_WIDTH-1:0]           o_ram_data_a,
  output logic                            o_ram_en_b,
  output logic [ADDR_WIDTH-1:0]           o_ram_addr_b,
  input  logic [DATA_WIDTH-1:0]           i_ram_data_b
);
  localparam int PW = ptr_width(ADDR_WIDTH);
  localparam int CW = cnt_width(ADDR_WIDTH);
  localparam int DEPTH = buf_depth(OUT_DELAY);
  localparam int BW = cnt_bits(DEPTH);
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, ram_cnt;
  logic [OUT_DELAY-1:0] vld_q, vld_d;
  logic ready_q, ready_d;
  logic [BW-1:0] buf_cnt, inflight;
  logic [BW:0] occ;
  logic full, empty, wr_en, rd_en, pop;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < OUT_DELAY; i++) inflight = inflight + BW'(vld_q[i]);
    occ          = {1'b0, inflight} + {1'b0, buf_cnt};
    empty        = wptr_q == rptr_q;
    full         = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
    o_wr_ready   = ready_q && !full;
    wr_en        = i_wr_valid && o_wr_ready;
    pop          = o_rd_valid && i_rd_ready;
    // a pop this cycle frees the slot the newly issued read will eventually land in
    rd_en        = !empty && (int'(occ) < DEPTH || pop);
    wptr_d       = wptr_q + PW'(wr_en);
    rptr_d       = rptr_q + PW'(rd_en);
    vld_d        = OUT_DELAY'({vld_q, rd_en});
    ready_d      = 1'b1;
    ram_cnt      = wptr_q - rptr_q;
    o_count      = CW'(ram_cnt) + CW'(inflight) + CW'(buf_cnt);
    o_ram_we_a   = wr_en;
    o_ram_addr_a = wptr_q[ADDR_WIDTH-1:0];
    o_ram_data_a = i_wr_data;
    o_ram_en_b   = rd_en;
    o_ram_addr_b = rptr_q[ADDR_WIDTH-1:0];
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      vld_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      vld_q   <= vld_d;
      ready_q <= ready_d;
    end
  dpram_rd_skid #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (vld_q[OUT_DELAY-1]),
    .i_data  (i_ram_data_b),
    .i_pop   (i_rd_ready),
    .o_data  (o_rd_data),
    .o_valid (o_rd_valid),
    .o_count (buf_cnt)
  );
endmodule
